cpuclk_ctrl: RTL
================

# cpuclk_ctrl

Parametrised CPU clock, wait-state and maskable-interrupt generator for the Z80 core. It derives clkcpu from clk28 through a programmable divider rather than fixed turbo taps. It stretches the clock for screen contention and for up to WAIT_CH independent wait-request channels with per-channel lengths. It raises /INT at a programmable raster position for a programmable number of CPU clocks.

## Interface
- DIV_W, 4: width of the clock-divider setting.
- WAIT_CH, 4: number of wait-request channels.
- WAIT_W, 3: width of each per-channel wait length, in clk28 cycles.
- INT_LEN_W, 6: width of the INT length setting.
- rst_n  in  1  asynchronous, active-low reset
- clk28  in  1  28 MHz system clock; all state on posedge
- div  in  DIV_W  clkcpu half-period minus 1, in clk28 cycles (0=14 MHz, 1=7 MHz, 3=3.5 MHz)
- cont_en  in  1  contention enable
- contention  in  1  contended access in progress (level, from video/bus decode)
- acc  in  1  bus access strobe (rd|wr)
- wait_req  in  WAIT_CH  per-channel wait request, sampled at access start
- wait_len  in  WAIT_CH*WAIT_W  packed lengths; channel i at [i*WAIT_W +: WAIT_W]
- vc, hc  in  9 each  raster counters
- int_v, int_h  in  9 each  INT start position
- int_len  in  INT_LEN_W  INT duration in CPU clocks; 0 disables INT
- clkcpu  out  1  CPU clock
- clkcpu_ck  out  1  one-clk28 pulse on the cycle after clkcpu rises
- clkwait  out  1  clock currently frozen
- n_int  out  1  registered /INT to the CPU
- n_int_next  out  1  combinational next value of n_int
- tstate  out  17  T-states since INT start (see Configuration)

## Operation
- Divider: counter cnt, DIV_W bits. On each clk28 with !clkwait: if cnt >= div then cnt<=0 and clkcpu<=~clkcpu; otherwise cnt<=cnt+1. The `>=` comparison makes a mid-cycle reduction of div take effect at once, with no wrap-around.
- clkwait = (cont_en && contention && clkcpu) || (wait_cnt != 0). While clkwait is high, clkcpu and cnt hold. Contention can therefore only freeze the high phase.
- Wait: acc_prev is registered. An access start is acc && !acc_prev. At access start with wait_cnt==0 and any wait_req bit set, wait_cnt <= wait_len of the lowest-index set channel.
- wait_cnt decrements every clk28 while nonzero.
- An access start while wait_cnt != 0 is ignored.
- A selected length of 0 inserts no wait.
- INT: int_cnt, INT_LEN_W bits. When int_cnt==0, int_len!=0, vc==int_v and hc==int_h, int_cnt <= 1.
- On clkcpu_ck with int_cnt != 0: if int_cnt >= int_len then int_cnt <= 0, otherwise int_cnt <= int_cnt + 1.
- A raster match while int_cnt != 0 is ignored.
- n_int_next = (int_cnt == 0). n_int <= n_int_next on clkcpu_ck.

## Timing
- Reset values: clkcpu=0, clkcpu_ck=0, clkwait=0, n_int=1, tstate=0. Internally cnt=0, wait_cnt=0 and int_cnt=0.
- A reset asserted mid-INT or mid-wait aborts it immediately.
- clkcpu period is 2*(div+1) clk28 cycles, plus stall cycles.
- An access start with wait length L stretches clkcpu by exactly L clk28 cycles. wait_cnt loads on the clk28 edge after acc rises.
- clkcpu_ck is high for exactly one clk28 cycle, on the cycle after each clkcpu rising edge.
- /INT latency: n_int falls on the first clkcpu_ck after the raster match. It stays low for int_len clkcpu_ck periods.

## Configuration
- CPUCLK_TSTATE_EN defined: a 17-bit counter increments on each clkcpu_ck. It is set to 0 on the clkcpu_ck where n_int falls, and saturates at all-ones.
- CPUCLK_TSTATE_EN undefined: tstate is tied to 0 and no counter logic is built.

## Structure
- Shared `common` package:
  - localparams CPUDIV_14=0, CPUDIV_7=1, CPUDIV_3_5=3;
  - default INT positions INT_V_S48=248/INT_H_S48=0, INT_V_S128=248/INT_H_S128=4, INT_V_PENT=239/INT_H_PENT=322.
- One sub-module, cpuclk_int, holds the INT counter, n_int register and tstate counter. Its inputs are clkcpu_ck, vc, hc, int_v, int_h and int_len.

## Test plan
- div=3, no waits, cont_en=0 -> clkcpu period 8 clk28 cycles; one clkcpu_ck per period.
- div=1, wait_req=4'b0110, wait_len ch1=3, ch2=5, acc rising -> clkcpu stretched by exactly 3 clk28 cycles (ch1 wins); a second acc edge during the wait -> no extra stretch.
- div=3, cont_en=1, contention held for 6 clk28 cycles starting in the low phase -> clkcpu low phase unaffected; the high phase is extended until contention drops.
- int_v=248, int_h=4, int_len=32 -> n_int low for exactly 32 clkcpu_ck periods starting on the first clkcpu_ck after vc=248/hc=4; int_len=0 -> n_int stays 1.
- div changed 7->1 when cnt=5 -> clkcpu toggles on the next enabled clk28, then period 4 cycles.
- rst_n asserted mid-INT with CPUCLK_TSTATE_EN defined -> n_int=1 and tstate=0 immediately; tstate reads 0 at the INT falling edge and counts clkcpu_ck afterwards.

Source files
------------

// File: rtl/common_pkg.sv
// Shared CPU clock presets and default INT raster positions for the Z80 clocking logic.
package common;

    localparam int CPUDIV_14  = 0;
    localparam int CPUDIV_7   = 1;
    localparam int CPUDIV_3_5 = 3;

    localparam int INT_V_S48  = 248;
    localparam int INT_H_S48  = 0;
    localparam int INT_V_S128 = 248;
    localparam int INT_H_S128 = 4;
    localparam int INT_V_PENT = 239;
    localparam int INT_H_PENT = 322;

endpackage

// File: rtl/cpuclk_ctrl_int.sv
// /INT generator: raster-triggered counter of clkcpu_ck periods, registered n_int; n_int
// moves on clkcpu_ck only. Optional tstate counter built when CPUCLK_TSTATE_EN is defined.
module cpuclk_int
    import common::*;
#(
    parameter int INT_LEN_W = 6
) (
    input  logic                 rst_n,
    input  logic                 clk28,
    input  logic                 clkcpu_ck,
    input  logic [8:0]           vc,
    input  logic [8:0]           hc,
    input  logic [8:0]           int_v,
    input  logic [8:0]           int_h,
    input  logic [INT_LEN_W-1:0] int_len,
    output logic                 n_int,
    output logic                 n_int_next,
    output logic [16:0]          tstate
);

    logic [INT_LEN_W-1:0] int_cnt;

    assign n_int_next = (int_cnt == '0);

    // A raster match is only honoured while idle; the count then advances on CPU clocks.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            int_cnt <= '0;
            n_int   <= 1'b1;
        end else begin
            if (int_cnt == '0) begin
                if ((int_len != '0) && (vc == int_v) && (hc == int_h))
                    int_cnt <= INT_LEN_W'(1);
            end else if (clkcpu_ck) begin
                if (int_cnt >= int_len)
                    int_cnt <= '0;
                else
                    int_cnt <= int_cnt + INT_LEN_W'(1);
            end
            if (clkcpu_ck)
                n_int <= n_int_next;
        end
    end

`ifdef CPUCLK_TSTATE_EN
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            tstate <= '0;
        end else if (clkcpu_ck) begin
            if (n_int && !n_int_next)
                tstate <= '0;
            else if (tstate != '1)
                tstate <= tstate + 17'd1;
        end
    end
`else
    assign tstate = '0;
`endif

endmodule

// File: rtl/cpuclk_ctrl.sv
// Z80 clock generator: programmable divider from clk28, stretched by contention and wait channels;
// clkwait is combinational, clkcpu_ck follows each clkcpu rise by one cycle. Macro: CPUCLK_TSTATE_EN.
module cpuclk_ctrl
    import common::*;
#(
    parameter int DIV_W     = 4,
    parameter int WAIT_CH   = 4,
    parameter int WAIT_W    = 3,
    parameter int INT_LEN_W = 6
) (
    input  logic                      rst_n,
    input  logic                      clk28,
    input  logic [DIV_W-1:0]          div,
    input  logic                      cont_en,
    input  logic                      contention,
    input  logic                      acc,
    input  logic [WAIT_CH-1:0]        wait_req,
    input  logic [WAIT_CH*WAIT_W-1:0] wait_len,
    input  logic [8:0]                vc,
    input  logic [8:0]                hc,
    input  logic [8:0]                int_v,
    input  logic [8:0]                int_h,
    input  logic [INT_LEN_W-1:0]      int_len,
    output logic                      clkcpu,
    output logic                      clkcpu_ck,
    output logic                      clkwait,
    output logic                      n_int,
    output logic                      n_int_next,
    output logic [16:0]               tstate
);

    logic [DIV_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_sel;
    logic              acc_prev;
    logic              acc_start;
    logic              half_done;

    assign clkwait   = (cont_en && contention && clkcpu) || (wait_cnt != '0);
    assign half_done = !clkwait && (cnt >= div);
    assign acc_start = acc && !acc_prev;

    // Descending scan so the lowest-index requesting channel wins.
    always_comb begin
        wait_sel = '0;
        for (int i = WAIT_CH - 1; i >= 0; i--) begin
            if (wait_req[i])
                wait_sel = wait_len[i*WAIT_W +: WAIT_W];
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clkcpu    <= 1'b0;
            clkcpu_ck <= 1'b0;
        end else begin
            clkcpu_ck <= half_done && !clkcpu;
            if (!clkwait) begin
                if (half_done) begin
                    cnt    <= '0;
                    clkcpu <= ~clkcpu;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            acc_prev <= 1'b0;
        end else begin
            acc_prev <= acc;
            if (wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
            else if (acc_start)
                wait_cnt <= wait_sel;
        end
    end

    cpuclk_int #(
        .INT_LEN_W (INT_LEN_W)
    ) u_int (
        .rst_n      (rst_n),
        .clk28      (clk28),
        .clkcpu_ck  (clkcpu_ck),
        .vc         (vc),
        .hc         (hc),
        .int_v      (int_v),
        .int_h      (int_h),
        .int_len    (int_len),
        .n_int      (n_int),
        .n_int_next (n_int_next),
        .tstate     (tstate)
    );

endmodule
